// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive FIFO: intake FSM encoding and default depth.
package uart_rx_fifo_pkg;

    localparam int UART_FIFO_DEPTH_LOG2 = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        SETTLE = 2'd2
    } intake_state_t;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo8.sv
// Generic byte FIFO: push is ignored when full and pop when empty, both judged on the pre-edge count.
module sync_fifo8 #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   COUNT_MAX = DEPTH[DEPTH_LOG2:0];

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == COUNT_MAX);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Drains bytes from the buart receiver into a FIFO read by the CPU; flags bytes dropped when full.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_valid,
    input  logic [7:0]            uart_data,
    output logic                  uart_rd,
    input  logic                  cpu_rd,
    output logic [7:0]            cpu_data,
    output logic                  cpu_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output intake_state_t         intake_state
);

    intake_state_t state;
    intake_state_t state_next;
    logic [7:0]    byte_q;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;

    // Handshake: buart holds uart_valid/uart_data until it sees the one-cycle
    // uart_rd pulse; the SETTLE cycle gives it time to drop uart_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (uart_valid) state_next = ACK;
            ACK:     state_next = SETTLE;
            SETTLE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // uart_rd is a flop tracking the ACK state so it is glitch-free and drops on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_rd <= 1'b0;
            byte_q  <= '0;
        end else begin
            uart_rd <= (state_next == ACK);
            if (state == IDLE && uart_valid) begin
                byte_q <= uart_data;
            end
        end
    end

    assign push = (state == ACK);

    // Clear wins over a same-cycle drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end else if (push && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo8 #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (byte_q),
        .pop       (cpu_rd),
        .head      (cpu_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (level)
    );

    assign cpu_valid    = ~fifo_empty;
    assign intake_state = state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte-queue reference model.
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    logic          clk;
    logic          reset;
    logic          uart_valid;
    logic [7:0]    uart_data;
    logic          uart_rd;
    logic          cpu_rd;
    logic [7:0]    cpu_data;
    logic          cpu_valid;
    logic [4:0]    level;
    logic          overflow;
    logic          clr_overflow;
    intake_state_t intake_state;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf;

    uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_valid   (uart_valid),
        .uart_data    (uart_data),
        .uart_rd      (uart_rd),
        .cpu_rd       (cpu_rd),
        .cpu_data     (cpu_data),
        .cpu_valid    (cpu_valid),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .intake_state (intake_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state();
        check_eq("level", 32'(level), 32'(exp_q.size()));
        check_eq("cpu_valid", 32'(cpu_valid), 32'(exp_q.size() != 0));
        check_eq("overflow", 32'(overflow), 32'(exp_ovf));
        if (exp_q.size() != 0) check_eq("cpu_data", 32'(cpu_data), 32'(exp_q[0]));
    endtask

    // One intake transaction; optional pop and overflow clear during the ACK cycle.
    task automatic intake(input logic [7:0] b, input bit with_pop, input bit with_clr);
        int  lvl0;
        bit  was_full;
        bit  was_empty;
        lvl0 = exp_q.size();
        uart_valid = 1'b1;
        uart_data  = b;
        step();
        check_eq("uart_rd_ack", 32'(uart_rd), 32'd1);
        check_eq("level_before_push", 32'(level), 32'(lvl0));
        uart_valid   = 1'b0;
        uart_data    = 8'h00;
        cpu_rd       = with_pop;
        clr_overflow = with_clr;
        step();
        cpu_rd       = 1'b0;
        clr_overflow = 1'b0;
        was_full  = (exp_q.size() == 16);
        was_empty = (exp_q.size() == 0);
        if (with_pop && !was_empty) void'(exp_q.pop_front());
        if (!was_full) exp_q.push_back(b);
        else exp_ovf = 1'b1;
        if (with_clr) exp_ovf = 1'b0;
        check_eq("uart_rd_settle", 32'(uart_rd), 32'd0);
        check_state();
        step();
    endtask

    task automatic pop_check();
        check_eq("head_before_pop", 32'(cpu_data), 32'(exp_q[0]));
        cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
        void'(exp_q.pop_front());
        check_state();
    endtask

    initial begin
        reset        = 1'b1;
        uart_valid   = 1'b0;
        uart_data    = 8'h00;
        cpu_rd       = 1'b0;
        clr_overflow = 1'b0;
        exp_ovf      = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // reset values
        check_eq("rst_uart_rd", 32'(uart_rd), 32'd0);
        check_eq("rst_state", 32'(intake_state), 32'(IDLE));
        check_state();

        // single byte
        intake(8'h41, 1'b0, 1'b0);
        check_eq("single_data", 32'(cpu_data), 32'h41);
        pop_check();

        // fill, partial drain, wrap around
        for (int i = 0; i < 16; i++) intake(8'(i), 1'b0, 1'b0);
        check_eq("fill_level", 32'(level), 32'd16);
        for (int i = 0; i < 8; i++) pop_check();
        for (int i = 16; i < 24; i++) intake(8'(i), 1'b0, 1'b0);
        for (int i = 8; i < 24; i++) begin
            check_eq("wrap_order", 32'(cpu_data), 32'(i));
            pop_check();
        end
        check_eq("wrap_no_ovf", 32'(overflow), 32'd0);

        // overflow, clear, same-cycle set+clear, full push+pop
        for (int i = 0; i < 16; i++) intake(8'hA0 + 8'(i), 1'b0, 1'b0);
        intake(8'hEE, 1'b0, 1'b0);
        check_eq("ovf_level", 32'(level), 32'd16);
        check_eq("ovf_flag", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        exp_ovf = 1'b0;
        check_eq("ovf_clr", 32'(overflow), 32'd0);
        intake(8'hEE, 1'b0, 1'b1);
        check_eq("ovf_set_clr", 32'(overflow), 32'd0);
        intake(8'hEE, 1'b1, 1'b0);
        check_eq("full_pushpop_level", 32'(level), 32'd15);
        check_eq("full_pushpop_ovf", 32'(overflow), 32'd1);
        for (int i = 1; i < 16; i++) begin
            check_eq("ovf_drain", 32'(cpu_data), 32'(8'hA0 + 8'(i)));
            pop_check();
        end
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        exp_ovf = 1'b0;

        // simultaneous push and pop
        intake(8'h31, 1'b0, 1'b0);
        intake(8'h32, 1'b0, 1'b0);
        intake(8'h33, 1'b0, 1'b0);
        intake(8'h34, 1'b1, 1'b0);
        check_eq("sim3_level", 32'(level), 32'd3);
        check_eq("sim3_head", 32'(cpu_data), 32'h32);
        repeat (3) pop_check();
        intake(8'h77, 1'b1, 1'b0);
        check_eq("sim0_level", 32'(level), 32'd1);
        check_eq("sim0_head", 32'(cpu_data), 32'h77);
        pop_check();

        // empty read
        cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
        check_eq("empty_rd_level", 32'(level), 32'd0);
        check_eq("empty_rd_valid", 32'(cpu_valid), 32'd0);
        intake(8'h55, 1'b0, 1'b0);
        check_eq("after_empty_data", 32'(cpu_data), 32'h55);

        // reset in the middle of ACK with data stored and overflow set
        for (int i = 0; i < 16; i++) intake(8'hC0 + 8'(i), 1'b0, 1'b0);
        check_eq("pre_rst_ovf", 32'(overflow), 32'd1);
        uart_valid = 1'b1;
        uart_data  = 8'h99;
        step();
        check_eq("mid_ack_uart_rd", 32'(uart_rd), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("async_rst_uart_rd", 32'(uart_rd), 32'd0);
        uart_valid = 1'b0;
        uart_data  = 8'h00;
        step();
        reset = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        step();
        check_eq("post_rst_state", 32'(intake_state), 32'(IDLE));
        check_state();
        intake(8'h3C, 1'b0, 1'b0);
        check_eq("post_rst_data", 32'(cpu_data), 32'h3C);
        pop_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer between the `buart` receiver and the CPU IO bus. It drains each byte from `buart` as soon as `valid` rises and stores it in a small FIFO. The CPU UART data/status registers read from this FIFO instead of from the receiver's single holding register. This removes byte loss when firmware is busy, for example while the CPU stalls on character RAM or is mid-scroll.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes, giving 16 entries by default.
- `clk`  in  1  system clock (25 MHz pixel/CPU clock).
- `reset`  in  1  asynchronous, active-high reset.
- `uart_valid`  in  1  `buart` has a received byte.
- `uart_data`  in  8  `buart` received byte.
- `uart_rd`  out  1  one-cycle acknowledge to `buart`; consumes the byte.
- `cpu_rd`  in  1  pop strobe: IO read strobe qualified by the UART data address bit.
- `cpu_data`  out  8  byte at FIFO head; undefined when empty.
- `cpu_valid`  out  1  FIFO not empty.
- `level`  out  DEPTH_LOG2+1  number of stored bytes, 0..2^DEPTH_LOG2.
- `overflow`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `clr_overflow`  in  1  clears `overflow`; synchronous, one cycle.

## Operation
- **Storage:** 2^DEPTH_LOG2 x 8 array.
  - `wr_ptr` and `rd_ptr` are DEPTH_LOG2 bits wide and wrap modulo depth.
  - `count` is DEPTH_LOG2+1 bits. `level = count`.
  - `cpu_valid = (count != 0)`.
  - `cpu_data = mem[rd_ptr]`, a combinational read of registered storage.
- **Intake FSM** with states IDLE, ACK, SETTLE:
  - IDLE → ACK when `uart_valid` = 1. `uart_data` is latched this cycle.
  - ACK: `uart_rd` = 1 for exactly this cycle.
    - If not full, write the latched byte to `mem[wr_ptr]` and advance `wr_ptr`.
    - If full, discard the byte and set `overflow`.
    - Always go to SETTLE.
  - SETTLE: one dead cycle so `buart` can drop `valid`. Always go to IDLE.
  - `uart_rd` is 0 in IDLE and SETTLE.
- **Pop:** `cpu_rd` with `count != 0` advances `rd_ptr` on that clock edge. `cpu_rd` on an empty FIFO is ignored; no pointer or count change.
- **Simultaneous push (ACK) and pop in one cycle:**
  - Both take effect and `count` is unchanged.
  - When full, the full test uses the pre-edge `count`, so the push is dropped and `overflow` is set even though a pop occurs in the same cycle.
  - When empty, the push lands, the pop is ignored, and `count` goes to 1.
- **Overflow flag:** `clr_overflow` has priority over a same-cycle overflow set, so the flag ends at 0.
- **Reset values:** FSM = IDLE, pointers = 0, `count` = 0, `uart_rd` = 0, `cpu_valid` = 0, `level` = 0, `overflow` = 0. Memory contents are not reset.
- **Reset mid-operation:** a byte latched in ACK is lost. `buart` sees `uart_rd` fall immediately.

## Timing
- `uart_valid` rising to `uart_rd` high: 1 cycle.
- `uart_valid` rising to `cpu_valid`/`level` updated: 2 cycles.
- Minimum intake spacing is 3 cycles per byte, far faster than 115200 baud (217 clk per bit).
- Pop: `cpu_data` and `level` show the next entry on the cycle after the `cpu_rd` edge.
- The CPU data path already registers IO read data at the read strobe, so the sampled value is the pre-pop head.
- All outputs are registered except `cpu_data` (array read) and `cpu_valid` (decode of `count`).

## Structure
- Shared package/include holds:
  - the FSM state encoding (2-bit: IDLE=0, ACK=1, SETTLE=2);
  - `UART_FIFO_DEPTH_LOG2 = 4`.
- One natural sub-module: `sync_fifo8`, a generic byte FIFO with push, pop, full, empty and count.
- `uart_rx_fifo` is that FIFO plus the intake FSM and the overflow flag.
- **Top-level integration (status register):** bits [9:0] keep their layout with `cpu_data`, the busy bit and `cpu_valid`. `level` occupies bits [15:11] and `overflow` occupies bit 16.

## Test plan
- **Reset:** assert `reset` mid-ACK → `uart_rd` = 0 immediately; `level` = 0, `cpu_valid` = 0, `overflow` = 0 after release.
- **Single byte:** `uart_valid` with 0x41 → `uart_rd` pulses 1 cycle, one cycle later. `cpu_valid` = 1, `cpu_data` = 0x41, `level` = 1. `cpu_rd` → `level` = 0, `cpu_valid` = 0.
- **Fill and wrap:** push 0x00..0x0F → `level` = 16. Pop 8, push 0x10..0x17, pop 16 → output sequence 0x08..0x17 in order, `overflow` = 0.
- **Overflow:** with 16 stored, push 0xEE → `uart_rd` still pulses, `level` stays 16, `overflow` = 1, and 0xEE never appears. `clr_overflow` → 0. Same-cycle set and clear → 0.
- **Simultaneous push and pop:** `level` = 3 with ACK in the same cycle as `cpu_rd` → `level` stays 3. `level` = 0 with the same coincidence → `level` = 1 and the pushed byte is at the head.
- **Empty read:** `cpu_rd` while empty → no change in `level` or pointers. A later push of 0x55 → `cpu_data` = 0x55.
